mem_access_unit: RTL

// - MEM-stage load/store unit between the EX/MEM register and the MEM/WB register.
// - Turns a load/store into a req/ack transaction on the data-memory port, with byte strobes.
// - Aligns and sign/zero-extends load data; passes ALU result and WB control through.
// - Drives the pipeline stall while a memory access is outstanding.

---
 rtl/mem_access_unit_if.sv | 22 ++
 rtl/mem_access_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// Data-memory port bundle between the MEM-stage load/store unit and data memory.
// The master issues req/we/addr/wdata; the slave returns a one-cycle ack with rdata.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              dm_req;
  logic [3:0]        dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata;
  logic              dm_ack;
  logic [31:0]       dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_ack, dm_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: req/ack data-memory access with byte strobes, load extension, stall.
// Optional MISALIGN_TRAP_EN suppresses misaligned accesses and adds the misalign_err output.
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  input  logic [2:0]        ex_funct3,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [31:0]       ex_wdata,
  input  logic [31:0]       ex_aludata,
  input  logic [4:0]        ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memtoreg,
  input  logic              ex_floatwb,
  mem_access_unit_if.master dm,
  output logic [31:0]       wb_data,
  output logic [31:0]       wb_aludata,
  output logic [4:0]        wb_rd,
  output logic              wb_regwrite,
  output logic              wb_memtoreg,
  output logic              wb_floatwb,
`ifdef MISALIGN_TRAP_EN
  output logic              misalign_err,
`endif
  output logic              stall
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state_reg, state_next;
  logic              dm_req_reg, dm_req_next;
  logic [3:0]        dm_we_reg, dm_we_next;
  logic [ADDR_W-1:0] dm_addr_reg, dm_addr_next;
  logic [31:0]       dm_wdata_reg, dm_wdata_next;
  logic [31:0]       load_reg, load_next;

  logic              memop;
  logic              issue;
  logic              trap;
  logic [1:0]        lane;
  logic [3:0]        store_we;
  logic [31:0]       store_wdata;
  logic [7:0]        rbyte [4];
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;
  logic [31:0]       load_ext;

  assign memop = ex_memread | ex_memwrite;
  assign lane  = ex_addr[1:0];

`ifdef MISALIGN_TRAP_EN
  // funct3[1:0] encodes access size for both loads and stores: 00 byte, 01 half, 10 word
  assign trap = memop && (((ex_funct3[1:0] == 2'b01) && ex_addr[0]) ||
                          ((ex_funct3[1:0] == 2'b10) && (ex_addr[1:0] != 2'b00)));
  assign misalign_err = (state_reg == IDLE) && trap;
`else
  assign trap = 1'b0;
`endif

  assign issue = memop && !trap;

  always_comb begin
    store_we    = 4'b1111;
    store_wdata = ex_wdata;
    case (ex_funct3[1:0])
      2'b00: begin
        store_we    = 4'b0001 << lane;
        store_wdata = {4{ex_wdata[7:0]}};
      end
      2'b01: begin
        store_we    = 4'b0011 << {lane[1], 1'b0};
        store_wdata = {2{ex_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rbyte
      assign rbyte[gi] = dm.dm_rdata[8*gi +: 8];
    end
  endgenerate

  assign sel_byte = rbyte[lane];
  assign sel_half = lane[1] ? dm.dm_rdata[31:16] : dm.dm_rdata[15:0];

  always_comb begin
    load_ext = dm.dm_rdata;
    case (ex_funct3)
      3'b000:  load_ext = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  load_ext = {24'd0, sel_byte};
      3'b001:  load_ext = {{16{sel_half[15]}}, sel_half};
      3'b101:  load_ext = {16'd0, sel_half};
      default: load_ext = dm.dm_rdata;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    dm_req_next   = dm_req_reg;
    dm_we_next    = dm_we_reg;
    dm_addr_next  = dm_addr_reg;
    dm_wdata_next = dm_wdata_reg;
    load_next     = load_reg;
    stall         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (issue) begin
          stall         = 1'b1;
          dm_req_next   = 1'b1;
          dm_addr_next  = {ex_addr[ADDR_W-1:2], 2'b00};
          dm_we_next    = ex_memwrite ? store_we : 4'b0000;
          dm_wdata_next = ex_memwrite ? store_wdata : 32'd0;
          state_next    = REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (dm.dm_ack) begin
          dm_req_next = 1'b0;
          dm_we_next  = 4'b0000;
          load_next   = ex_memwrite ? 32'd0 : load_ext;
          state_next  = DONE;
        end
      end
      // The stalled EX/MEM instruction is still present here; never re-issue it.
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      dm_req_reg   <= 1'b0;
      dm_we_reg    <= 4'b0000;
      dm_addr_reg  <= '0;
      dm_wdata_reg <= 32'd0;
      load_reg     <= 32'd0;
    end else begin
      state_reg    <= state_next;
      dm_req_reg   <= dm_req_next;
      dm_we_reg    <= dm_we_next;
      dm_addr_reg  <= dm_addr_next;
      dm_wdata_reg <= dm_wdata_next;
      load_reg     <= load_next;
    end
  end

  assign dm.dm_req   = dm_req_reg;
  assign dm.dm_we    = dm_we_reg;
  assign dm.dm_addr  = dm_addr_reg;
  assign dm.dm_wdata = dm_wdata_reg;

  assign wb_data     = (state_reg == DONE) ? load_reg : 32'd0;
  assign wb_aludata  = ex_aludata;
  assign wb_rd       = ex_rd;
  assign wb_regwrite = ex_regwrite && !trap;
  assign wb_memtoreg = ex_memtoreg;
  assign wb_floatwb  = ex_floatwb;

endmodule
